cram_loader: RTL and testbench

Word-wide, multi-lane configuration loader for the fabric's CRAM shift chains. It replaces the single-bit `config_data_in` / `config_en` serial path into each tile with `LANES` parallel chains, fed from a valid/ready word stream. It adds non-destructive readback: each chain recirculates while its bits are packed into output words. It sits between the configuration host interface and the heads/tails of the tile CRAM chains, and holds the user fabric off while configuration is in progress.

---
 rtl/cram_loader_pkg.sv | 22 ++
 rtl/cram_word_shifter.sv | 30 +++
 rtl/cram_loader.sv | 172 +++++++++++++++++
 tb/tb_cram_loader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cram_loader_pkg.sv
// rtl/cram_loader_pkg.sv - shared types and helpers for the multi-lane CRAM loader
package cram_loader_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_WAIT  = 3'd1,
        WR_SHIFT = 3'd2,
        RB_SHIFT = 3'd3,
        RB_OUT   = 3'd4
    } state_e;

    typedef enum logic {
        CRAM_WRITE    = 1'b0,
        CRAM_READBACK = 1'b1
    } mode_e;

    // Counter width for a 0..n-1 count, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cram_word_shifter.sv
// rtl/cram_word_shifter.sv - word register: parallel load / LANES-bit shift out, LANES-bit shift in / parallel read
module cram_word_shifter #(
    parameter int WORD_W = 32,
    parameter int LANES  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic              shift,
    input  logic [LANES-1:0]  shift_in,
    output logic [LANES-1:0]  lanes_out,
    output logic [WORD_W-1:0] word
);

    // One right shift serves both directions: the low lanes leave first,
    // captured lanes enter at the top and reach the bottom after a full word.
    always_ff @(posedge clk) begin
        if (rst) begin
            word <= '0;
        end else if (load) begin
            word <= load_data;
        end else if (shift) begin
            word <= {shift_in, word[WORD_W-1:LANES]};
        end
    end

    assign lanes_out = word[LANES-1:0];

endmodule

// File: rtl/cram_loader.sv
// rtl/cram_loader.sv - word-stream to multi-lane CRAM chain loader with recirculating readback
module cram_loader
    import cram_loader_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int CHAIN_LEN = 256,
    parameter int WORD_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic              abort,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [WORD_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [WORD_W-1:0] rd_data,
    output logic              cfg_en,
    output logic [LANES-1:0]  cfg_dout,
    input  logic [LANES-1:0]  cfg_din,
    output logic              busy,
    output logic              done,
    output logic              fabric_hold
);

    localparam int SPW    = WORD_W / LANES;
    localparam int NWORDS = CHAIN_LEN * LANES / WORD_W;
    localparam int SCW    = cnt_w(SPW);
    localparam int WCW    = cnt_w(NWORDS);
    localparam logic [SCW-1:0] SHIFT_LAST = SCW'(SPW - 1);
    localparam logic [WCW-1:0] WORD_LAST  = WCW'(NWORDS - 1);

    localparam logic [2:0] S_IDLE     = IDLE;
    localparam logic [2:0] S_WR_WAIT  = WR_WAIT;
    localparam logic [2:0] S_WR_SHIFT = WR_SHIFT;
    localparam logic [2:0] S_RB_SHIFT = RB_SHIFT;
    localparam logic [2:0] S_RB_OUT   = RB_OUT;

    logic [2:0]       state;
    mode_e            mode_q;
    logic [SCW-1:0]   shift_cnt;
    logic [WCW-1:0]   word_cnt;
    logic [LANES-1:0] dout_q;

    logic              sh_load;
    logic              sh_shift;
    logic [LANES-1:0]  sh_lanes;
    logic [WORD_W-1:0] sh_word;

    // Step 0 goes straight to dout_q at the handshake, so the shifter keeps
    // the remaining steps and its low lanes are always the next step.
    assign sh_load  = (state == S_WR_WAIT) && wr_valid && !abort;
    assign sh_shift = (state == S_WR_SHIFT) || (state == S_RB_SHIFT);

    cram_word_shifter #(
        .WORD_W (WORD_W),
        .LANES  (LANES)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (sh_load),
        .load_data (wr_data >> LANES),
        .shift     (sh_shift),
        .shift_in  (cfg_din),
        .lanes_out (sh_lanes),
        .word      (sh_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            mode_q    <= CRAM_WRITE;
            shift_cnt <= '0;
            word_cnt  <= '0;
            dout_q    <= '0;
            cfg_en    <= 1'b0;
            wr_ready  <= 1'b0;
            rd_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && state != S_IDLE) begin
                state    <= S_IDLE;
                dout_q   <= '0;
                cfg_en   <= 1'b0;
                wr_ready <= 1'b0;
                rd_valid <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            shift_cnt <= '0;
                            word_cnt  <= '0;
                            busy      <= 1'b1;
                            mode_q    <= mode_e'(mode);
                            if (mode == CRAM_READBACK) begin
                                state  <= S_RB_SHIFT;
                                cfg_en <= 1'b1;
                            end else begin
                                state    <= S_WR_WAIT;
                                wr_ready <= 1'b1;
                            end
                        end
                    end
                    S_WR_WAIT: begin
                        if (wr_valid) begin
                            state    <= S_WR_SHIFT;
                            wr_ready <= 1'b0;
                            cfg_en   <= 1'b1;
                            dout_q   <= wr_data[LANES-1:0];
                        end
                    end
                    S_WR_SHIFT: begin
                        if (shift_cnt == SHIFT_LAST) begin
                            shift_cnt <= '0;
                            cfg_en    <= 1'b0;
                            dout_q    <= '0;
                            if (word_cnt == WORD_LAST) begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                word_cnt <= word_cnt + 1'b1;
                                state    <= S_WR_WAIT;
                                wr_ready <= 1'b1;
                            end
                        end else begin
                            shift_cnt <= shift_cnt + 1'b1;
                            dout_q    <= sh_lanes;
                        end
                    end
                    S_RB_SHIFT: begin
                        if (shift_cnt == SHIFT_LAST) begin
                            shift_cnt <= '0;
                            cfg_en    <= 1'b0;
                            rd_valid  <= 1'b1;
                            state     <= S_RB_OUT;
                        end else begin
                            shift_cnt <= shift_cnt + 1'b1;
                        end
                    end
                    S_RB_OUT: begin
                        if (rd_ready) begin
                            rd_valid <= 1'b0;
                            if (word_cnt == WORD_LAST) begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                word_cnt <= word_cnt + 1'b1;
                                state    <= S_RB_SHIFT;
                                cfg_en   <= 1'b1;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // The tail bit must reach the head on the same edge it leaves the chain,
    // so readback bypasses dout_q; the select itself comes only from registers.
    assign cfg_dout    = (cfg_en && mode_q == CRAM_READBACK) ? cfg_din : dout_q;
    assign rd_data     = sh_word;
    assign fabric_hold = busy;

endmodule

// File: tb/tb_cram_loader.sv
// tb/tb_cram_loader.sv - self-checking bench for cram_loader with a behavioural CRAM chain model
module tb_cram_loader;

    localparam int LANES     = 4;
    localparam int CHAIN_LEN = 4;
    localparam int WORD_W    = 8;
    localparam int SPW       = WORD_W / LANES;
    localparam int NWORDS    = CHAIN_LEN * LANES / WORD_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              mode;
    logic              abort;
    logic              wr_valid;
    logic              wr_ready;
    logic [WORD_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [WORD_W-1:0] rd_data;
    logic              cfg_en;
    logic [LANES-1:0]  cfg_dout;
    logic [LANES-1:0]  cfg_din;
    logic              busy;
    logic              done;
    logic              fabric_hold;

    int checks = 0;
    int errors = 0;

    logic [CHAIN_LEN-1:0] chain [LANES];
    logic [WORD_W-1:0]    exp_mem [NWORDS];

    cram_loader #(
        .LANES     (LANES),
        .CHAIN_LEN (CHAIN_LEN),
        .WORD_W    (WORD_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode        (mode),
        .abort       (abort),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .cfg_en      (cfg_en),
        .cfg_dout    (cfg_dout),
        .cfg_din     (cfg_din),
        .busy        (busy),
        .done        (done),
        .fabric_hold (fabric_hold)
    );

    always #5 clk = ~clk;

    // Fabric chain: bit 0 is the tail, the head bit enters at the top on each enabled edge.
    always_comb begin
        cfg_din = '0;
        for (int l = 0; l < LANES; l++) cfg_din[l] = chain[l][0];
    end

    always @(posedge clk) begin
        if (cfg_en) begin
            for (int l = 0; l < LANES; l++) chain[l] <= {cfg_dout[l], chain[l][CHAIN_LEN-1:1]};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_hold"}, fabric_hold, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_wr_ready"}, wr_ready, 0);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_cfg_en"}, cfg_en, 0);
        check({tag, "_cfg_dout"}, cfg_dout, 0);
        check({tag, "_rd_data"}, rd_data, 0);
    endtask

    // Full write pass; optionally pokes start/mode mid-pass to show it is ignored.
    task automatic do_write(input logic [WORD_W-1:0] w0, input logic [WORD_W-1:0] w1, input bit poke);
        logic [WORD_W-1:0] w [NWORDS];
        logic [WORD_W-1:0] t;
        w[0] = w0;
        w[1] = w1;
        start = 1'b1;
        mode  = 1'b0;
        step();
        start = 1'b0;
        check("wr_busy", busy, 1);
        check("wr_hold", fabric_hold, 1);
        for (int k = 0; k < NWORDS; k++) begin
            check("wr_ready_up", wr_ready, 1);
            wr_valid = 1'b1;
            wr_data  = w[k];
            step();
            wr_valid = 1'b0;
            wr_data  = WORD_W'($urandom);
            for (int s = 0; s < SPW; s++) begin
                t = w[k] >> (s * LANES);
                check("wr_cfg_en", cfg_en, 1);
                check("wr_cfg_dout", cfg_dout, t[LANES-1:0]);
                check("wr_ready_low", wr_ready, 0);
                if (poke && k == 0 && s == 0) begin
                    start = 1'b1;
                    mode  = 1'b1;
                end
                step();
                start = 1'b0;
                mode  = 1'b0;
            end
            check("wr_gap_cfg_en", cfg_en, 0);
            if (k < NWORDS - 1) begin
                check("wr_gap_done", done, 0);
                check("wr_gap_busy", busy, 1);
            end else begin
                check("wr_done", done, 1);
                check("wr_end_busy", busy, 0);
                check("wr_end_hold", fabric_hold, 0);
                step();
                check("wr_done_pulse", done, 0);
            end
        end
        for (int k = 0; k < NWORDS; k++) exp_mem[k] = w[k];
    endtask

    task automatic do_readback(input int stall);
        start    = 1'b1;
        mode     = 1'b1;
        rd_ready = 1'b0;
        step();
        start = 1'b0;
        mode  = 1'b0;
        check("rb_busy", busy, 1);
        for (int k = 0; k < NWORDS; k++) begin
            for (int s = 0; s < SPW; s++) begin
                check("rb_cfg_en", cfg_en, 1);
                check("rb_valid_low", rd_valid, 0);
                step();
            end
            check("rb_valid", rd_valid, 1);
            check("rb_data", rd_data, exp_mem[k]);
            check("rb_out_cfg_en", cfg_en, 0);
            if (k == 0) begin
                for (int i = 0; i < stall; i++) begin
                    step();
                    check("rb_stall_valid", rd_valid, 1);
                    check("rb_stall_data", rd_data, exp_mem[k]);
                    check("rb_stall_cfg_en", cfg_en, 0);
                end
            end
            rd_ready = 1'b1;
            step();
            rd_ready = 1'b0;
        end
        check("rb_done", done, 1);
        check("rb_end_busy", busy, 0);
        check("rb_end_valid", rd_valid, 0);
        step();
        check("rb_done_pulse", done, 0);
    endtask

    initial begin
        for (int l = 0; l < LANES; l++) chain[l] = CHAIN_LEN'($urandom);
        rst      = 1'b1;
        start    = 1'b0;
        mode     = 1'b0;
        abort    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;
        step();

        // wr_valid while idle must not start anything
        wr_valid = 1'b1;
        wr_data  = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_wr_ready", wr_ready, 0);
            check("idle_cfg_en", cfg_en, 0);
            check("idle_busy", busy, 0);
        end
        wr_valid = 1'b0;

        do_write(8'hA5, 8'h3C, 1'b1);
        do_readback(0);
        do_readback(5);

        // abort in the inter-word bubble
        start = 1'b1;
        step();
        start    = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 8'h77;
        step();
        wr_valid = 1'b0;
        step();
        step();
        check("ab_in_wait", wr_ready, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("ab_busy", busy, 0);
        check("ab_wr_ready", wr_ready, 0);
        check("ab_cfg_en", cfg_en, 0);
        check("ab_done", done, 0);
        step();
        check("ab_done_later", done, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("ab_idle_busy", busy, 0);

        do_write(WORD_W'($urandom), WORD_W'($urandom), 1'b0);
        do_readback(1);

        // reset in the middle of a shift
        start = 1'b1;
        step();
        start    = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 8'hC3;
        step();
        wr_valid = 1'b0;
        check("rs_pre_cfg_en", cfg_en, 1);
        rst = 1'b1;
        step();
        check_all_zero("mid_reset");
        rst = 1'b0;
        step();

        for (int r = 0; r < 4; r++) begin
            do_write(WORD_W'($urandom), WORD_W'($urandom), r[0]);
            do_readback(int'($urandom_range(0, 3)));
            do_readback(0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
